// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : Counts apples eaten and maintains the committed score, its
//               BCD tens/units digits and the session high score. Apple
//               edges accumulate in a small pending counter. Points are
//               committed one per frame_end, during vertical blanking, so the
//               displayed score never changes mid-frame.
// Ports       : clock_25      in   pixel clock, single clock domain
//               sync_reset    in   synchronous active-high reset (clears all)
//               apple_eaten   in   level; each rising edge = +1 point
//               game_over     in   level; entering high freezes scoring
//               new_game      in   1-cycle pulse; clears score, keeps high
//               frame_end     in   1-cycle pulse at start of vblank
//               score         out  committed score, binary
//               score_dec     out  committed tens digit, BCD
//               score_unit    out  committed units digit, BCD
//               high_score    out  best committed score since sync_reset
//               score_max     out  score has reached MAX_SCORE
//               score_changed out  1-cycle pulse after each commit
// Revision    : 1.0 - initial release
// ============================================================================
module score_tracker #(
    parameter int SCORE_BITS = 7,
    parameter int MAX_SCORE  = 99,   // must fit in two BCD digits (<= 99)
    parameter int PEND_BITS  = 2
) (
    input  logic                  clock_25,
    input  logic                  sync_reset,
    input  logic                  apple_eaten,
    input  logic                  game_over,
    input  logic                  new_game,
    input  logic                  frame_end,
    output logic [SCORE_BITS-1:0] score,
    output logic [3:0]            score_dec,
    output logic [3:0]            score_unit,
    output logic [SCORE_BITS-1:0] high_score,
    output logic                  score_max,
    output logic                  score_changed
);

    typedef enum logic [0:0] {
        ST_PLAY   = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    localparam logic [SCORE_BITS-1:0] c_max_score = SCORE_BITS'(MAX_SCORE);
    localparam logic [PEND_BITS-1:0]  c_pend_full = '1;

    state_t                r_state;
    logic                  r_apple_prev;
    logic [PEND_BITS-1:0]  r_pending;
    logic [SCORE_BITS-1:0] r_score;
    logic [3:0]            r_dec;
    logic [3:0]            r_unit;
    logic [SCORE_BITS-1:0] r_high;
    logic                  r_max;
    logic                  r_changed;

    logic                  w_edge;
    logic                  w_pend_nz;
    logic                  w_below_max;
    logic                  w_commit;
    logic                  w_flush;
    logic [SCORE_BITS-1:0] w_score_inc;

    // Edges only count while playing; once frozen, apples are ignored but
    // points already pending still commit.
    assign w_edge      = apple_eaten & ~r_apple_prev & (r_state == ST_PLAY);
    assign w_pend_nz   = (r_pending != '0);
    assign w_below_max = (r_score < c_max_score);
    assign w_commit    = frame_end & w_pend_nz & w_below_max;
    // At saturation the backlog is discarded instead of committed.
    assign w_flush     = frame_end & w_pend_nz & ~w_below_max;
    assign w_score_inc = r_score + SCORE_BITS'(1);

    always_ff @(posedge clock_25) begin
        if (sync_reset) begin
            r_state      <= ST_PLAY;
            r_apple_prev <= 1'b0;
            r_pending    <= '0;
            r_score      <= '0;
            r_dec        <= 4'd0;
            r_unit       <= 4'd0;
            r_high       <= '0;
            r_max        <= 1'b0;
            r_changed    <= 1'b0;
        end else begin
            r_apple_prev <= apple_eaten;
            r_changed    <= 1'b0;

            if (new_game) begin
                // Restart wins over any same-cycle edge or commit.
                r_state   <= ST_PLAY;
                r_pending <= '0;
                r_score   <= '0;
                r_dec     <= 4'd0;
                r_unit    <= 4'd0;
                r_max     <= 1'b0;
            end else begin
                if (r_state == ST_PLAY && game_over) begin
                    r_state <= ST_FROZEN;
                end

                if (w_flush) begin
                    r_pending <= '0;
                end else if (w_commit && !w_edge) begin
                    r_pending <= r_pending - PEND_BITS'(1);
                end else if (w_edge && !w_commit && r_pending != c_pend_full) begin
                    r_pending <= r_pending + PEND_BITS'(1);
                end
                // edge + commit together: pending unchanged

                if (w_commit) begin
                    r_score   <= w_score_inc;
                    r_changed <= 1'b1;
                    r_max     <= (w_score_inc == c_max_score);
                    if (r_unit == 4'd9) begin
                        r_unit <= 4'd0;
                        r_dec  <= r_dec + 4'd1;
                    end else begin
                        r_unit <= r_unit + 4'd1;
                    end
                    if (w_score_inc > r_high) begin
                        r_high <= w_score_inc;
                    end
                end
            end
        end
    end

    assign score         = r_score;
    assign score_dec     = r_dec;
    assign score_unit    = r_unit;
    assign high_score    = r_high;
    assign score_max     = r_max;
    assign score_changed = r_changed;

endmodule
`default_nettype wire
